// File: rtl/instr_fetch.sv
// Program counter and fetch sequencer for the 9-bit core: IDLE/RUN/HALT control,
// sequential/branch next-PC selection and a 4-entry programmable branch-target LUT.
module instr_fetch #(
  parameter int              PC_W       = 10,
  parameter logic [PC_W-1:0] START_ADDR = '0
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic            Jump,
  input  logic            BranchEn,
  input  logic [1:0]      TargSel,
  input  logic            Ack,
  input  logic            LutWrEn,
  input  logic [1:0]      LutAddr,
  input  logic [PC_W-1:0] LutData,
  output logic [PC_W-1:0] ProgCtr,
  output logic            Running,
  output logic            Done
);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  state_t          state, state_nxt;
  logic [PC_W-1:0] pc_nxt;
  logic [PC_W-1:0] lut [4];

  always_comb begin
    state_nxt = state;
    pc_nxt    = ProgCtr;
    unique case (state)
      IDLE: begin
        if (Start) begin
          state_nxt = RUN;
          pc_nxt    = START_ADDR;
        end
      end
      RUN: begin
        // The halt word must stay on ProgCtr, so Ack outranks any branch.
        if (Ack)
          state_nxt = HALT;
        else if (BranchEn && Jump)
          pc_nxt = lut[TargSel];
        else
          pc_nxt = ProgCtr + PC_ONE;
      end
      HALT: begin
        if (Start) begin
          state_nxt = RUN;
          pc_nxt    = START_ADDR;
        end
      end
      default: begin
        state_nxt = IDLE;
        pc_nxt    = '0;
      end
    endcase
  end

  // The branch read above sees the pre-edge LUT contents, so a same-cycle
  // write only becomes visible to the next branch.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= IDLE;
      ProgCtr <= '0;
      for (int i = 0; i < 4; i++) lut[i] <= '0;
    end else begin
      state   <= state_nxt;
      ProgCtr <= pc_nxt;
      if (LutWrEn) lut[LutAddr] <= LutData;
    end
  end

  assign Running = (state == RUN);
  assign Done    = (state == HALT);

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: per-cycle stimulus and expected
// {ProgCtr, Running, Done} are queued together and compared after each edge.
module tb_instr_fetch;

  typedef struct packed {
    logic [9:0] pc;
    logic       running;
    logic       done;
  } exp_t;

  typedef struct packed {
    logic       reset;
    logic       start;
    logic       ack;
    logic       ben;
    logic       jump;
    logic [1:0] ts;
    logic       lwe;
    logic [1:0] la;
    logic [9:0] ld;
  } stim_t;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1, Start = 1'b0, Jump = 1'b0, BranchEn = 1'b0, Ack = 1'b0;
  logic [1:0] TargSel = 2'd0, LutAddr = 2'd0;
  logic       LutWrEn = 1'b0;
  logic [9:0] LutData = 10'd0;
  logic [9:0] ProgCtr;
  logic       Running, Done;

  logic       Reset4 = 1'b1, Start4 = 1'b0;
  logic [3:0] ProgCtr4;
  logic       Running4, Done4;

  exp_t  sbq[$];
  stim_t stq[$];
  int    vectors = 0;
  int    miscompares = 0;

  always #5 Clk = ~Clk;

  instr_fetch #(.PC_W(10), .START_ADDR(10'd0)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Jump(Jump), .BranchEn(BranchEn),
    .TargSel(TargSel), .Ack(Ack), .LutWrEn(LutWrEn), .LutAddr(LutAddr),
    .LutData(LutData), .ProgCtr(ProgCtr), .Running(Running), .Done(Done)
  );

  instr_fetch #(.PC_W(4), .START_ADDR(4'd14)) dut4 (
    .Clk(Clk), .Reset(Reset4), .Start(Start4), .Jump(Jump), .BranchEn(BranchEn),
    .TargSel(TargSel), .Ack(Ack), .LutWrEn(LutWrEn), .LutAddr(LutAddr),
    .LutData(LutData[3:0]), .ProgCtr(ProgCtr4), .Running(Running4), .Done(Done4)
  );

  function automatic stim_t mk(logic rst, logic st, logic ack, logic ben, logic jmp,
                               logic [1:0] ts, logic lwe, logic [1:0] la, logic [9:0] ld);
    stim_t s;
    s = '{rst, st, ack, ben, jmp, ts, lwe, la, ld};
    return s;
  endfunction

  task automatic add(stim_t s, logic [9:0] pc, logic run, logic dn);
    exp_t e;
    e = '{pc, run, dn};
    stq.push_back(s);
    sbq.push_back(e);
  endtask

  task automatic drive(stim_t s);
    Reset    = s.reset;
    Start    = s.start;
    Ack      = s.ack;
    BranchEn = s.ben;
    Jump     = s.jump;
    TargSel  = s.ts;
    LutWrEn  = s.lwe;
    LutAddr  = s.la;
    LutData  = s.ld;
  endtask

  task automatic test_reset();
    stim_t s; exp_t e, got; int n = 0;
    add(mk(1,0,0,0,0,0,0,0,0), 10'd0, 0, 0);
    add(mk(1,1,1,1,1,2,1,1,10'h155), 10'd0, 0, 0);
    add(mk(0,0,0,0,0,0,0,0,0), 10'd0, 0, 0);
    while (stq.size() > 0) begin
      s = stq.pop_front(); drive(s);
      @(posedge Clk); #1;
      e = sbq.pop_front(); got = {ProgCtr, Running, Done}; vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL reset step %0d: got pc=%h run=%b done=%b, expected pc=%h run=%b done=%b",
                 n, got.pc, got.running, got.done, e.pc, e.running, e.done);
      end
      n++;
    end
  endtask

  task automatic test_sequential();
    stim_t s; exp_t e, got; int n = 0;
    add(mk(1,0,0,0,0,0,0,0,0), 10'd0, 0, 0);
    add(mk(0,1,0,0,0,0,0,0,0), 10'd0, 1, 0);
    for (int i = 1; i <= 5; i++) add(mk(0,0,0,0,0,0,0,0,0), 10'(i), 1, 0);
    while (stq.size() > 0) begin
      s = stq.pop_front(); drive(s);
      @(posedge Clk); #1;
      e = sbq.pop_front(); got = {ProgCtr, Running, Done}; vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL sequential step %0d: got pc=%h run=%b done=%b, expected pc=%h run=%b done=%b",
                 n, got.pc, got.running, got.done, e.pc, e.running, e.done);
      end
      n++;
    end
  endtask

  task automatic test_branch();
    stim_t s; exp_t e, got; int n = 0;
    add(mk(1,0,0,0,0,0,0,0,0), 10'd0, 0, 0);
    add(mk(0,0,0,0,0,0,1,2,10'h040), 10'd0, 0, 0);
    add(mk(0,1,0,0,0,0,0,0,0), 10'd0, 1, 0);
    for (int i = 1; i <= 3; i++) add(mk(0,0,0,0,0,0,0,0,0), 10'(i), 1, 0);
    add(mk(0,0,0,1,0,2,0,0,0), 10'd4, 1, 0);     // branch not taken
    add(mk(0,0,0,0,1,2,0,0,0), 10'd5, 1, 0);     // Jump without BranchEn
    add(mk(0,0,0,1,1,2,0,0,0), 10'h040, 1, 0);   // taken
    add(mk(0,0,0,0,0,0,0,0,0), 10'h041, 1, 0);
    add(mk(0,0,0,1,1,0,0,0,0), 10'h000, 1, 0);   // LUT[0] still clear
    while (stq.size() > 0) begin
      s = stq.pop_front(); drive(s);
      @(posedge Clk); #1;
      e = sbq.pop_front(); got = {ProgCtr, Running, Done}; vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL branch step %0d: got pc=%h run=%b done=%b, expected pc=%h run=%b done=%b",
                 n, got.pc, got.running, got.done, e.pc, e.running, e.done);
      end
      n++;
    end
  endtask

  task automatic test_halt();
    stim_t s; exp_t e, got; int n = 0;
    add(mk(1,0,0,0,0,0,0,0,0), 10'd0, 0, 0);
    add(mk(0,0,0,0,0,0,1,2,10'h033), 10'd0, 0, 0);
    add(mk(0,1,0,0,0,0,0,0,0), 10'd0, 1, 0);
    for (int i = 1; i <= 7; i++) add(mk(0,0,0,0,0,0,0,0,0), 10'(i), 1, 0);
    for (int i = 0; i < 4; i++) add(mk(0,0,1,1,1,2,0,0,0), 10'd7, 0, 1);
    add(mk(0,1,0,0,0,0,0,0,0), 10'd0, 1, 0);     // restart from HALT
    add(mk(0,1,0,0,0,0,0,0,0), 10'd1, 1, 0);     // Start ignored in RUN
    add(mk(0,0,1,0,0,0,0,0,0), 10'd1, 0, 1);
    add(mk(1,1,0,0,0,0,0,0,0), 10'd0, 0, 0);     // reset from HALT beats Start
    while (stq.size() > 0) begin
      s = stq.pop_front(); drive(s);
      @(posedge Clk); #1;
      e = sbq.pop_front(); got = {ProgCtr, Running, Done}; vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL halt step %0d: got pc=%h run=%b done=%b, expected pc=%h run=%b done=%b",
                 n, got.pc, got.running, got.done, e.pc, e.running, e.done);
      end
      n++;
    end
  endtask

  task automatic test_lut_same_cycle();
    stim_t s; exp_t e, got; int n = 0;
    add(mk(1,0,0,0,0,0,0,0,0), 10'd0, 0, 0);
    add(mk(0,0,0,0,0,0,1,1,10'h0AA), 10'd0, 0, 0);
    add(mk(0,1,0,0,0,0,0,0,0), 10'd0, 1, 0);
    add(mk(0,0,0,1,1,1,1,1,10'h055), 10'h0AA, 1, 0);
    add(mk(0,0,0,1,1,1,0,0,0), 10'h055, 1, 0);
    add(mk(0,0,0,0,0,0,1,3,10'h3FF), 10'h056, 1, 0);  // write in RUN
    add(mk(0,0,0,1,1,3,0,0,0), 10'h3FF, 1, 0);
    add(mk(0,0,0,0,0,0,0,0,0), 10'h000, 1, 0);        // 10-bit wrap
    while (stq.size() > 0) begin
      s = stq.pop_front(); drive(s);
      @(posedge Clk); #1;
      e = sbq.pop_front(); got = {ProgCtr, Running, Done}; vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL lut_same_cycle step %0d: got pc=%h run=%b done=%b, expected pc=%h run=%b done=%b",
                 n, got.pc, got.running, got.done, e.pc, e.running, e.done);
      end
      n++;
    end
  endtask

  task automatic test_reset_midrun();
    stim_t s; exp_t e, got; int n = 0;
    add(mk(1,0,0,0,0,0,0,0,0), 10'd0, 0, 0);
    for (int i = 0; i < 4; i++) add(mk(0,0,0,0,0,0,1,2'(i),10'h100 + 10'(i)), 10'd0, 0, 0);
    add(mk(0,1,0,0,0,0,0,0,0), 10'd0, 1, 0);
    for (int i = 1; i <= 9; i++) add(mk(0,0,0,0,0,0,0,0,0), 10'(i), 1, 0);
    add(mk(1,1,0,1,1,1,1,0,10'h3FF), 10'd0, 0, 0);
    add(mk(0,0,0,0,0,0,0,0,0), 10'd0, 0, 0);
    add(mk(0,1,0,0,0,0,0,0,0), 10'd0, 1, 0);
    add(mk(0,0,0,0,0,0,0,0,0), 10'd1, 1, 0);
    for (int i = 0; i < 4; i++) add(mk(0,0,0,1,1,2'(i),0,0,0), 10'd0, 1, 0);
    while (stq.size() > 0) begin
      s = stq.pop_front(); drive(s);
      @(posedge Clk); #1;
      e = sbq.pop_front(); got = {ProgCtr, Running, Done}; vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL reset_midrun step %0d: got pc=%h run=%b done=%b, expected pc=%h run=%b done=%b",
                 n, got.pc, got.running, got.done, e.pc, e.running, e.done);
      end
      n++;
    end
  endtask

  task automatic test_wrap_pc4();
    stim_t s; exp_t e, got; int n = 0;
    add(mk(1,0,0,0,0,0,0,0,0), 10'd0, 0, 0);
    add(mk(0,1,0,0,0,0,0,0,0), 10'd14, 1, 0);
    add(mk(0,0,0,0,0,0,0,0,0), 10'd15, 1, 0);
    add(mk(0,0,0,0,0,0,0,0,0), 10'd0, 1, 0);
    add(mk(0,0,0,0,0,0,0,0,0), 10'd1, 1, 0);
    while (stq.size() > 0) begin
      s = stq.pop_front();
      drive(mk(1,0,0,0,0,0,0,0,0));
      Reset4 = s.reset;
      Start4 = s.start;
      @(posedge Clk); #1;
      e = sbq.pop_front(); got = {6'd0, ProgCtr4, Running4, Done4}; vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL wrap_pc4 step %0d: got pc=%h run=%b done=%b, expected pc=%h run=%b done=%b",
                 n, got.pc, got.running, got.done, e.pc, e.running, e.done);
      end
      n++;
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_halt();
    test_lut_same_cycle();
    test_reset_midrun();
    test_wrap_pc4();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
